// File: rtl/axi_lite_times_table_slave.sv
// axi_lite_times_table_slave: AXI4-lite slave holding the 8x8 times table in 64 x 32-bit registers, writable for patching
module axi_lite_times_table_slave #(
    parameter int ADDR_LSB   = 0,
    parameter bit TABLE_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic [31:0] mem [64];
    logic        live, aw_full, w_full;
    logic [31:0] aw_addr, w_data;
    logic [3:0]  w_strb;
    logic        aw_fire, w_fire, ar_fire, commit, aw_ok, ar_ok;
    logic [5:0]  aw_idx, ar_idx;

    // live holds the readies low while reset is asserted
    assign s_axi_bvalid  = w_state == W_RESP;
    assign s_axi_rvalid  = r_state == R_DATA;
    assign s_axi_awready = live && !aw_full && !s_axi_bvalid;
    assign s_axi_wready  = live && !w_full && !s_axi_bvalid;
    assign s_axi_arready = live && !s_axi_rvalid;
    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    assign ar_fire = s_axi_arvalid && s_axi_arready;
    assign commit  = aw_full && w_full;
    assign aw_idx  = aw_addr[ADDR_LSB +: 6];
    assign ar_idx  = s_axi_araddr[ADDR_LSB +: 6];
    assign aw_ok   = (aw_addr >> (ADDR_LSB + 6)) == 32'd0;
    assign ar_ok   = (s_axi_araddr >> (ADDR_LSB + 6)) == 32'd0;

    always_comb begin
        w_next = (w_state == W_IDLE) ? (commit ? W_RESP : W_IDLE) : (s_axi_bready ? W_IDLE : W_RESP);
        r_next = (r_state == R_IDLE) ? (ar_fire ? R_DATA : R_IDLE) : (s_axi_rready ? R_IDLE : R_DATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live        <= 1'b0;
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            aw_addr     <= 32'd0;
            w_data      <= 32'd0;
            w_strb      <= 4'd0;
            s_axi_bresp <= 2'b00;
            s_axi_rresp <= 2'b00;
            s_axi_rdata <= 32'd0;
            for (int i = 0; i < 64; i++)
                mem[i] <= TABLE_INIT ? 32'(i[5:3]) * 32'(i[2:0]) : 32'd0;
        end else begin
            live <= 1'b1;
            if (aw_fire) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end
            if (w_fire) begin
                w_full <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (commit) begin
                aw_full     <= 1'b0;
                w_full      <= 1'b0;
                s_axi_bresp <= aw_ok ? 2'b00 : 2'b10;
                for (int k = 0; k < 4; k++)
                    if (aw_ok && w_strb[k]) mem[aw_idx][8*k +: 8] <= w_data[8*k +: 8];
            end
            // nonblocking update means a same-edge read sees the pre-write word
            if (ar_fire) begin
                s_axi_rdata <= ar_ok ? mem[ar_idx] : 32'd0;
                s_axi_rresp <= ar_ok ? 2'b00 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_times_table_slave.sv
// tb_axi_lite_times_table_slave: directed checks of the times-table AXI4-lite slave
module tb_axi_lite_times_table_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int checks = 0;
    int errors = 0;

    axi_lite_times_table_slave dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    // called and returning at posedge+1; ok = rvalid seen exactly one cycle after the AR handshake
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output bit ok);
        int n = 0;
        araddr = a;
        arvalid = 1'b1;
        rready = 1'b1;
        while (!arready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        ok = rvalid && n < 20;
        d = rdata;
        r = rresp;
        @(posedge clk); #1;
        ok = ok && !rvalid;
    endtask

    // AW and W in the same cycle; ok = bvalid low at buffer-full cycle, high after commit, low after bready
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output bit ok);
        awaddr = a;
        wdata = d;
        wstrb = s;
        awvalid = 1'b1;
        wvalid = 1'b1;
        bready = 1'b0;
        ok = awready && wready;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        ok = ok && !bvalid;
        @(posedge clk); #1;
        ok = ok && bvalid;
        r = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        ok = ok && !bvalid;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if ({rdata, bresp, rresp} !== 36'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h bresp=%b rresp=%b expected 0", rdata, bresp, rresp);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic_read();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        do_read(32'h3E, d, r, ok);
        checks++;
        if (!ok || d !== 32'd42 || r !== 2'b00) begin
            errors++;
            $display("FAIL read_3e: ok=%0d rdata=%0d rresp=%b expected ok=1 rdata=42 rresp=00", ok, d, r);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++) begin
                do_read({26'd0, 3'(a), 3'(b)}, d, r, ok);
                checks++;
                if (!ok || d !== 32'(a * b) || r !== 2'b00) begin
                    errors++;
                    $display("FAIL sweep_%0dx%0d: ok=%0d rdata=%0d rresp=%b expected %0d 00", a, b, ok, d, r, a * b);
                end
            end
    endtask

    task automatic test_write_same_cycle();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        do_write(32'h3E, 32'hDEADBEEF, 4'b0011, r, ok);
        checks++;
        if (!ok || r !== 2'b00) begin
            errors++;
            $display("FAIL write_same_cycle: ok=%0d bresp=%b expected ok=1 bresp=00", ok, r);
        end
        do_read(32'h3E, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL strobe_merge: ok=%0d rdata=%h expected 0000beef", ok, d);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        wdata = 32'd5;
        wstrb = 4'hF;
        wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL w_buffered_ready: wready=%b awready=%b expected 0 1", wready, awready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL w_alone_no_resp: bvalid=%b expected 0", bvalid);
        end
        awaddr = 32'h01;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        ok = !bvalid;
        @(posedge clk); #1;
        checks++;
        if (!ok || bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL w_then_aw_resp: early_ok=%0d bvalid=%b bresp=%b expected 1 1 00", ok, bvalid, bresp);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        do_read(32'h01, d, r, ok);
        checks++;
        if (!ok || d !== 32'd5) begin
            errors++;
            $display("FAIL w_then_aw_data: ok=%0d rdata=%0d expected 5", ok, d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        do_read(32'h40, d, r, ok);
        checks++;
        if (!ok || d !== 32'd0 || r !== 2'b10) begin
            errors++;
            $display("FAIL oor_read: ok=%0d rdata=%h rresp=%b expected 0 10", ok, d, r);
        end
        do_write(32'h100, 32'hFFFFFFFF, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 2'b10) begin
            errors++;
            $display("FAIL oor_write: ok=%0d bresp=%b expected 10", ok, r);
        end
        do_read(32'h00, d, r, ok);
        checks++;
        if (!ok || d !== 32'd0 || r !== 2'b00) begin
            errors++;
            $display("FAIL oor_no_change: ok=%0d rdata=%h rresp=%b expected 0 00", ok, d, r);
        end
    endtask

    task automatic test_rready_stall();
        araddr = 32'h1B;
        arvalid = 1'b1;
        rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'd9 || rresp !== 2'b00 || arready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: rvalid=%b rdata=%0d rresp=%b arready=%b expected 1 9 00 0",
                         i, rvalid, rdata, rresp, arready);
            end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: rvalid=%b arready=%b expected 0 1", rvalid, arready);
        end
    endtask

    task automatic test_back_to_back();
        araddr = 32'h3F;
        arvalid = 1'b1;
        rready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rvalid !== (i % 2 == 0) || (rvalid && rdata !== 32'd49)) begin
                errors++;
                $display("FAIL b2b_%0d: rvalid=%b rdata=%0d expected rvalid=%0d rdata=49", i, rvalid, rdata, i % 2 == 0);
            end
        end
        arvalid = 1'b0;
    endtask

    task automatic test_same_index();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        awaddr = 32'h2A;
        wdata = 32'h77;
        wstrb = 4'hF;
        awvalid = 1'b1;
        wvalid = 1'b1;
        bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        araddr = 32'h2A;
        arvalid = 1'b1;
        rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'd10 || bvalid !== 1'b1) begin
            errors++;
            $display("FAIL same_index_old: rvalid=%b rdata=%0d bvalid=%b expected 1 10 1", rvalid, rdata, bvalid);
        end
        rready = 1'b1;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        do_read(32'h2A, d, r, ok);
        checks++;
        if (!ok || d !== 32'h77) begin
            errors++;
            $display("FAIL same_index_new: ok=%0d rdata=%h expected 77", ok, d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        bit seen = 1'b0;
        awaddr = 32'h3E;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        rst = 1'b0;
        #2;
        checks++;
        if ({awready, wready, arready, bvalid} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset_flags: got %b expected 0000", {awready, wready, arready, bvalid});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        wdata = 32'h0;
        wstrb = 4'hF;
        wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen = seen | bvalid;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_resp: bvalid seen=%0d expected 0", seen);
        end
        do_read(32'h3E, d, r, ok);
        checks++;
        if (!ok || d !== 32'd42) begin
            errors++;
            $display("FAIL mid_reset_data: ok=%0d rdata=%0d expected 42", ok, d);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_sweep();
        test_write_same_cycle();
        test_w_before_aw();
        test_out_of_range();
        test_rready_stall();
        test_back_to_back();
        test_same_index();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
